bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Multi-digit synchronous BCD up/down counter with parallel load, terminal-count and wrap indication.
- Consumes the lab6 negative-edge flip-flop stage: all state is held in negative-edge storage and updates on the falling edge of clk.
- Drives 7-segment decode and display logic downstream.

Parameters:
- NUM_DIGITS, 2, number of BCD digits; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on negedge clk.
- reset_n  input  1  synchronous active-low reset, sampled on negedge clk.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  parallel load strobe.
- load_val  input  4*NUM_DIGITS  BCD load value; digit 0 is bits [3:0].
- count  output  4*NUM_DIGITS  current BCD count, registered.
- tc  output  1  terminal count, combinational: en & up & count==all-9s, or en & ~up & count==0.
- wrap  output  1  registered pulse, high for exactly one cycle after a wrap event.

Behaviour:
- One clock; reset is synchronous and active-low. Port names are clk and reset_n.
- Reset values: count=0 and wrap=0. tc follows count and en, so tc=0 after reset unless en=1 and up=0.
- Priority at each negedge clk: reset_n=0, then load=1, then en=1, then hold.
- Load:
  - count <= load_val at the next negedge.
  - Any digit greater than 9 is replaced by 9, per digit.
  - wrap <= 0. Load ignores en and up.
- Count up:
  - Digit i increments when en=1 and all lower digits are 9.
  - A digit at 9 rolls to 0.
- Count down:
  - Digit i decrements when en=1 and all lower digits are 0.
  - A digit at 0 rolls to 9.
- Wrap event: en=1, no load, and tc=1 at the sampling edge.
  - Up from all-9s gives all-0s; down from 0 gives all-9s.
  - wrap <= 1 on that edge and returns to 0 on the next edge unless another wrap occurs.
- Latency: one negedge from input sampling to count update. tc has zero latency.
- Direction change mid-count takes effect on the next enabled edge with no glitch state.
- en=0 holds count; wrap clears to 0 on that edge.
- reset_n low during load or count clears state regardless. Counting resumes from 0 on the first edge with reset_n=1.
- Invalid digit values (A–F) in count are unreachable except via X at power-up; reset defines state.
- No posedge logic is allowed.

Optional Feature:
- Macro BCD_COUNTER_SAT_EN.
- Defined: saturating mode.
  - At all-9s counting up, or at 0 counting down, count holds.
  - tc stays as defined; wrap never asserts and is tied to 0.
- Undefined: modular wrap as specified above.

Decomposition:
- Package bcd_pkg contains:
  - BCD_MAX = 4'd9 and BCD_ZERO = 4'd0;
  - typedef bcd_digit_t (4-bit);
  - the function bcd_clamp (min of digit and 9).
- Sub-module bcd_digit: one 4-bit negative-edge digit cell.
  - Inputs: clk, reset_n, load, ld_digit, inc, dec.
  - Outputs: digit, is_max, is_zero.
  - The top level instantiates NUM_DIGITS copies with a generate loop and builds the inc/dec ripple-enable chain combinationally.

Test Plan:
- Reset: drive reset_n=0 for 2 negedges with en=1, up=1 -> count=8'h00, wrap=0. After release, 3 enabled edges -> count=8'h03.
- Up wrap: load 8'h98, then en=1, up=1 -> count 99 with tc=1, then 00. wrap=1 for exactly one cycle after the 99->00 edge.
- Down borrow: load 8'h10, en=1, up=0 -> 09, then 08. Continuing to 00 gives tc=1; the next edge gives 99 with wrap pulse.
- Load clamp and priority: load=1, en=1, load_val=8'hAF -> count=8'h99; load wins over count.
- Mid-operation reset: count at 8'h57, assert reset_n=0 together with load=1, load_val=8'h12 -> count=8'h00.
- SAT_EN build: at 8'h99, up, en=1 for 3 edges -> count stays 8'h99, wrap=0. At 8'h00, down -> count stays 8'h00.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load-value clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A-F) are forced to 9 so the count never leaves BCD.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell held in falling-edge storage: reset, clamped load,
// increment with 9->0 roll and decrement with 0->9 roll, in that priority.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t digit,
  output logic       is_max,
  output logic       is_zero
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(ld_digit);
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_max  = (digit_q == BCD_MAX);
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_updown_counter.sv
// NUM_DIGITS-digit BCD up/down counter with parallel load, tc and wrap pulse.
// Define BCD_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    wrap
);

  logic [NUM_DIGITS-1:0] inc;
  logic [NUM_DIGITS-1:0] dec;
  logic [NUM_DIGITS-1:0] is_max;
  logic [NUM_DIGITS-1:0] is_zero;
  logic                  all_max;
  logic                  all_zero;
  logic                  cnt_up;
  logic                  cnt_dn;

  assign all_max  = &is_max;
  assign all_zero = &is_zero;
  assign tc       = en & (up ? all_max : all_zero);

`ifdef BCD_COUNTER_SAT_EN
  // At the terminal value the chain is never started, so the count holds.
  assign cnt_up = en & up & ~load & ~all_max;
  assign cnt_dn = en & ~up & ~load & ~all_zero;
  assign wrap   = 1'b0;
`else
  logic wrap_q;
  logic wrap_d;

  assign cnt_up = en & up & ~load;
  assign cnt_dn = en & ~up & ~load;
  assign wrap_d = en & ~load & tc;

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Ripple enable: a digit moves only when every lower digit is rolling over.
      if (gi == 0) begin : g_lsd
        assign inc[gi] = cnt_up;
        assign dec[gi] = cnt_dn;
      end else begin : g_upper
        assign inc[gi] = inc[gi-1] & is_max[gi-1];
        assign dec[gi] = dec[gi-1] & is_zero[gi-1];
      end

      bcd_digit u_digit (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .ld_digit (load_val[4*gi +: 4]),
        .inc      (inc[gi]),
        .dec      (dec[gi]),
        .digit    (count[4*gi +: 4]),
        .is_max   (is_max[gi]),
        .is_zero  (is_zero[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: driver pushes the expected pre-edge state per cycle, monitor compares.
module tb_bcd_updown_counter;

  localparam int ND = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic            up;
  logic            load;
  logic [4*ND-1:0] load_val;
  logic [4*ND-1:0] count;
  logic            tc;
  logic            wrap;

  typedef struct {
    string           name;
    bit              chk;
    logic [4*ND-1:0] cnt;
    logic            wr;
    logic            tcv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  bcd_updown_counter #(.NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Drive just after posedge; expected values describe what the monitor
  // should see just before the following negedge.
  task automatic step(input string nm, input bit chk, input logic r, input logic e,
                      input logic u, input logic l, input logic [4*ND-1:0] lv,
                      input logic [4*ND-1:0] c, input logic w, input logic t);
    exp_t x;
    @(posedge clk);
    #1;
    reset_n  = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    x.name = nm; x.chk = chk; x.cnt = c; x.wr = w; x.tcv = t;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #4;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk) begin
          n_cmp++;
          if (count !== x.cnt) begin
            n_bad++;
            $display("FAIL %s count: got %h expected %h", x.name, count, x.cnt);
          end
          n_cmp++;
          if (wrap !== x.wr) begin
            n_bad++;
            $display("FAIL %s wrap: got %b expected %b", x.name, wrap, x.wr);
          end
          n_cmp++;
          if (tc !== x.tcv) begin
            n_bad++;
            $display("FAIL %s tc: got %b expected %b", x.name, tc, x.tcv);
          end
          $display("cycle %s: count=%h wrap=%b tc=%b", x.name, count, wrap, tc);
        end
      end
    end
  end

  initial begin : driver
    reset_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
`ifdef BCD_COUNTER_SAT_EN
    step("rst0",    0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("rst1",    1, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("ld99",    1, 1, 0, 1, 1, 8'h99, 8'h00, 0, 0);
    step("sat_up1", 1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1);
    step("sat_up2", 1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1);
    step("sat_up3", 1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1);
    step("dn99",    1, 1, 1, 0, 0, 8'h00, 8'h99, 0, 0);
    step("ld00",    1, 1, 0, 0, 1, 8'h00, 8'h98, 0, 0);
    step("sat_dn1", 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    step("sat_dn2", 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    step("up00",    1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("final",   1, 1, 0, 1, 0, 8'h00, 8'h01, 0, 0);
`else
    step("rst0",    0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("rst1",    1, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("up_a",    1, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    step("up_b",    1, 1, 1, 1, 0, 8'h00, 8'h01, 0, 0);
    step("up_c",    1, 1, 1, 1, 0, 8'h00, 8'h02, 0, 0);
    step("ld98",    1, 1, 0, 1, 1, 8'h98, 8'h03, 0, 0);
    step("up98",    1, 1, 1, 1, 0, 8'h00, 8'h98, 0, 0);
    step("up99",    1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1);
    step("wrapup",  1, 1, 1, 1, 0, 8'h00, 8'h00, 1, 0);
    step("hold",    1, 1, 0, 1, 0, 8'h00, 8'h01, 0, 0);
    step("ld10",    1, 1, 0, 1, 1, 8'h10, 8'h01, 0, 0);
    step("dn10",    1, 1, 1, 0, 0, 8'h00, 8'h10, 0, 0);
    step("dn09",    1, 1, 1, 0, 0, 8'h00, 8'h09, 0, 0);
    step("ld01",    1, 1, 0, 0, 1, 8'h01, 8'h08, 0, 0);
    step("dn01",    1, 1, 1, 0, 0, 8'h00, 8'h01, 0, 0);
    step("dn00",    1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    step("wrapdn",  1, 1, 0, 0, 0, 8'h00, 8'h99, 1, 0);
    step("ldAF",    1, 1, 1, 1, 1, 8'hAF, 8'h99, 0, 1);
    step("ld57",    1, 1, 0, 1, 1, 8'h57, 8'h99, 0, 0);
    step("rst_ld",  1, 0, 1, 1, 1, 8'h12, 8'h57, 0, 0);
    step("dn_rst",  1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1);
    step("up_99b",  1, 1, 1, 1, 0, 8'h00, 8'h99, 1, 1);
    step("en0clr",  1, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0);
    step("ld_tc",   1, 1, 1, 0, 1, 8'h00, 8'h00, 0, 1);
    step("ld3A",    1, 1, 0, 1, 1, 8'h3A, 8'h00, 0, 0);
    step("up39",    1, 1, 1, 1, 0, 8'h00, 8'h39, 0, 0);
    step("final",   1, 1, 0, 1, 0, 8'h00, 8'h40, 0, 0);
`endif
    repeat (3) @(posedge clk);
    #6;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
